// File: rtl/ef_smsdac_seg_enc.sv
// ef_smsdac_seg_enc: segmented mismatch-shaping encoder for the SMS DAC.
// Maps an unsigned DW-bit sample onto NSEG binary-weighted 3-level elements
// (weights 1,2,...,2^(NSEG-1)). Each layer except the top keeps one toggle
// bit so that odd residues alternate between +1 and -1. This first-order
// shapes the element usage error. The encoder has one register stage.
// Optional feature macro: SMSDAC_OVLD_CNT_EN adds the ovld_cnt output, a
// saturating count of cycles on which ovld is produced.
module ef_smsdac_seg_enc #(
   parameter int DW   = 5,
   parameter int NSEG = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                in_valid,
   input  logic                static_mode,
   input  logic [DW-1:0]       d_in,
   output logic [2*NSEG-1:0]   d_out,
   output logic                out_valid,
`ifdef SMSDAC_OVLD_CNT_EN
   output logic [15:0]         ovld_cnt,
`endif
   output logic                ovld
);

   // Signed working width; it holds +/-(2^NSEG) with margin.
   localparam int W = NSEG + 2;
   localparam logic signed [W-1:0] MID_C  = W'(32'sd1 <<< (DW - 1));
   localparam logic signed [W-1:0] LMAX_C = W'((32'sd1 <<< NSEG) - 32'sd1);
   localparam logic signed [W-1:0] P1_C   = W'(32'sd1);
   localparam logic signed [W-1:0] N1_C   = W'(-32'sd1);
   localparam logic signed [W-1:0] Z_C    = W'(32'sd0);

   if ((DW < 2) || (DW > NSEG + 1) || (NSEG < 2) || (NSEG > 8)) begin : g_bad_param
      $error("ef_smsdac_seg_enc: illegal DW/NSEG combination");
   end

   // Element drive code {p,n}: +1 -> 10, -1 -> 01, 0 -> 00. The 11 code is never produced.
   function automatic logic [1:0] enc_drive(input logic signed [W-1:0] r);
      logic [1:0] code;
      case (r)
         P1_C:    code = 2'b10;
         N1_C:    code = 2'b01;
         default: code = 2'b00;
      endcase
      return code;
   endfunction

   logic [2*NSEG-1:0] d_out_q, d_out_d;
   logic              out_valid_q;
   logic              ovld_q, ovld_d;
   logic [NSEG-2:0]   st_q, st_d;

   logic signed [W-1:0] v_s;
   logic signed [W-1:0] r_s;
   logic signed [W-1:0] lim_s;
   logic signed [W-1:0] mag_s;

   // Offset, clamp and layer-by-layer split of the sample into element drives.
   always_comb begin
      d_out_d = '0;
      ovld_d  = 1'b0;
      st_d    = st_q;
      r_s     = Z_C;
      lim_s   = Z_C;
      mag_s   = Z_C;
      v_s     = $signed({{(W-DW){1'b0}}, d_in}) - MID_C;
      if (!in_valid) begin
         v_s = Z_C;
      end else if (v_s < -LMAX_C) begin
         v_s    = -LMAX_C;
         ovld_d = 1'b1;
      end else begin
         v_s = v_s;
      end
      for (int k = 0; k < NSEG - 1; k++) begin
         // Largest residue magnitude that the remaining layers can still represent.
         lim_s = W'((32'sd1 <<< (NSEG - k)) - 32'sd1);
         mag_s = v_s[W-1] ? -v_s : v_s;
         if (v_s[0] == 1'b0) begin
            r_s = Z_C;
         end else if (mag_s == lim_s) begin
            // Full-scale residue: the sign is forced and the toggle bit cannot be honoured.
            r_s    = v_s[W-1] ? N1_C : P1_C;
            ovld_d = 1'b1;
         end else if (static_mode) begin
            r_s = P1_C;
         end else begin
            r_s     = st_q[k] ? N1_C : P1_C;
            st_d[k] = ~st_q[k];
         end
         d_out_d[2*k +: 2] = enc_drive(r_s);
         v_s = (v_s - r_s) >>> 1;
      end
      // Top element takes whatever remains, always in {-1,0,+1}.
      d_out_d[2*(NSEG-1) +: 2] = enc_drive(v_s);
   end

   // Output register stage and per-layer toggle state.
   always_ff @(posedge clk) begin
      if (rst) begin
         d_out_q     <= '0;
         out_valid_q <= 1'b0;
         ovld_q      <= 1'b0;
         st_q        <= '0;
      end else begin
         d_out_q     <= d_out_d;
         out_valid_q <= in_valid;
         ovld_q      <= ovld_d;
         st_q        <= st_d;
      end
   end

   assign d_out     = d_out_q;
   assign out_valid = out_valid_q;
   assign ovld      = ovld_q;

`ifdef SMSDAC_OVLD_CNT_EN
   logic [15:0] ovld_cnt_q, ovld_cnt_d;

   // Next count: advance alongside each registered ovld, holding at all-ones.
   always_comb begin
      if (ovld_d && (ovld_cnt_q != 16'hFFFF)) begin
         ovld_cnt_d = ovld_cnt_q + 16'd1;
      end else begin
         ovld_cnt_d = ovld_cnt_q;
      end
   end

   // Overload event counter register.
   always_ff @(posedge clk) begin
      if (rst) begin
         ovld_cnt_q <= 16'd0;
      end else begin
         ovld_cnt_q <= ovld_cnt_d;
      end
   end

   assign ovld_cnt = ovld_cnt_q;
`endif

endmodule

// File: tb/tb_ef_smsdac_seg_enc.sv
// tb_ef_smsdac_seg_enc: directed vector table plus a random sum-invariant sweep
// for ef_smsdac_seg_enc at DW=5, NSEG=4.
module tb_ef_smsdac_seg_enc;

   logic       clk;
   logic       rst;
   logic       in_valid;
   logic       static_mode;
   logic [4:0] d_in;
   logic [7:0] d_out;
   logic       out_valid;
   logic       ovld;
`ifdef SMSDAC_OVLD_CNT_EN
   logic [15:0] ovld_cnt;
`endif

   int checks = 0;
   int errors = 0;

   ef_smsdac_seg_enc #(.DW(5), .NSEG(4)) dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .static_mode (static_mode),
      .d_in        (d_in),
      .d_out       (d_out),
      .out_valid   (out_valid),
`ifdef SMSDAC_OVLD_CNT_EN
      .ovld_cnt    (ovld_cnt),
`endif
      .ovld        (ovld)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       rst;
      logic       iv;
      logic       sm;
      logic [4:0] din;
      logic [7:0] dout;
      logic       ov;
      logic       ovld;
   } vec_t;

   vec_t tbl[$];

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Weighted sum of the element drives; flags any 11 code.
   function automatic int decode(input logic [7:0] d, output bit bad);
      int sum;
      sum = 0;
      bad = 1'b0;
      for (int k = 0; k < 4; k++) begin
         case (d[2*k +: 2])
            2'b10:   sum = sum + (1 << k);
            2'b01:   sum = sum - (1 << k);
            2'b11:   bad = 1'b1;
            default: sum = sum;
         endcase
      end
      return sum;
   endfunction

   initial begin
      int  exp_s;
      int  got_s;
      bit  bad;
      logic r_iv, r_sm, r_rst;
      logic [4:0] r_din;

      rst = 1'b1; in_valid = 1'b0; static_mode = 1'b0; d_in = 5'd16;

      //                  rst   iv    sm    din     dout    ov    ovld
      tbl.push_back(vec_t'{1'b1, 1'b0, 1'b0, 5'd16, 8'h00, 1'b0, 1'b0});
      tbl.push_back(vec_t'{1'b1, 1'b1, 1'b0, 5'd31, 8'h00, 1'b0, 1'b0});
      for (int i = 0; i < 4; i++)
         tbl.push_back(vec_t'{1'b0, 1'b1, 1'b0, 5'd16, 8'h00, 1'b1, 1'b0});
      tbl.push_back(vec_t'{1'b0, 1'b1, 1'b0, 5'd17, 8'h02, 1'b1, 1'b0});
      tbl.push_back(vec_t'{1'b0, 1'b1, 1'b0, 5'd17, 8'h09, 1'b1, 1'b0});
      tbl.push_back(vec_t'{1'b0, 1'b1, 1'b0, 5'd31, 8'hAA, 1'b1, 1'b1});
      tbl.push_back(vec_t'{1'b0, 1'b1, 1'b0, 5'd0,  8'h55, 1'b1, 1'b1});
      tbl.push_back(vec_t'{1'b0, 1'b1, 1'b0, 5'd17, 8'h02, 1'b1, 1'b0});
      tbl.push_back(vec_t'{1'b0, 1'b1, 1'b0, 5'd17, 8'h25, 1'b1, 1'b0});
      tbl.push_back(vec_t'{1'b0, 1'b0, 1'b0, 5'd31, 8'h00, 1'b0, 1'b0});
      for (int i = 0; i < 3; i++)
         tbl.push_back(vec_t'{1'b0, 1'b1, 1'b1, 5'd17, 8'h02, 1'b1, 1'b0});
      tbl.push_back(vec_t'{1'b0, 1'b1, 1'b1, 5'd19, 8'h0A, 1'b1, 1'b0});
      tbl.push_back(vec_t'{1'b0, 1'b1, 1'b0, 5'd17, 8'h02, 1'b1, 1'b0});
      tbl.push_back(vec_t'{1'b0, 1'b1, 1'b0, 5'd15, 8'h01, 1'b1, 1'b0});
      tbl.push_back(vec_t'{1'b0, 1'b1, 1'b0, 5'd13, 8'h12, 1'b1, 1'b0});
      tbl.push_back(vec_t'{1'b0, 1'b1, 1'b0, 5'd24, 8'h80, 1'b1, 1'b0});
      tbl.push_back(vec_t'{1'b0, 1'b1, 1'b0, 5'd8,  8'h40, 1'b1, 1'b0});
      tbl.push_back(vec_t'{1'b0, 1'b1, 1'b0, 5'd1,  8'h55, 1'b1, 1'b1});
      tbl.push_back(vec_t'{1'b0, 1'b1, 1'b0, 5'd30, 8'hA8, 1'b1, 1'b1});
      tbl.push_back(vec_t'{1'b0, 1'b1, 1'b0, 5'd17, 8'h09, 1'b1, 1'b0});
      // Reset mid-stream, then the toggle state must restart from zero.
      tbl.push_back(vec_t'{1'b1, 1'b1, 1'b0, 5'd17, 8'h00, 1'b0, 1'b0});
      tbl.push_back(vec_t'{1'b0, 1'b1, 1'b0, 5'd17, 8'h02, 1'b1, 1'b0});
      tbl.push_back(vec_t'{1'b0, 1'b1, 1'b0, 5'd17, 8'h09, 1'b1, 1'b0});

      foreach (tbl[i]) begin
         rst = tbl[i].rst; in_valid = tbl[i].iv; static_mode = tbl[i].sm; d_in = tbl[i].din;
         step();
         chk($sformatf("vec%0d_d_out", i), {8'h00, d_out}, {8'h00, tbl[i].dout});
         chk($sformatf("vec%0d_out_valid", i), {15'd0, out_valid}, {15'd0, tbl[i].ov});
         chk($sformatf("vec%0d_ovld", i), {15'd0, ovld}, {15'd0, tbl[i].ovld});
      end

`ifdef SMSDAC_OVLD_CNT_EN
      rst = 1'b1; in_valid = 1'b0; static_mode = 1'b0; d_in = 5'd16;
      step();
      chk("ovld_cnt_reset", ovld_cnt, 16'd0);
      rst = 1'b0; in_valid = 1'b1; d_in = 5'd31;
      for (int i = 0; i < 5; i++) step();
      in_valid = 1'b0;
      step();
      chk("ovld_cnt_five", ovld_cnt, 16'd5);
`endif

      // Random sweep: the decoded weighted sum must equal the clamped offset sample.
      for (int i = 0; i < 10000; i++) begin
         r_rst = (i == 5000) ? 1'b1 : 1'b0;
         r_iv  = ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0;
         r_sm  = ($urandom_range(0, 7) == 0) ? 1'b1 : 1'b0;
         r_din = 5'($urandom_range(0, 31));
         rst = r_rst; in_valid = r_iv; static_mode = r_sm; d_in = r_din;
         step();
         if (r_rst) begin
            chk("rnd_reset_d_out", {8'h00, d_out}, 16'h0000);
            chk("rnd_reset_out_valid", {15'd0, out_valid}, 16'd0);
         end else begin
            chk("rnd_out_valid", {15'd0, out_valid}, {15'd0, r_iv});
            if (r_iv) begin
               exp_s = int'(r_din) - 16;
               if (exp_s < -15) exp_s = -15;
               got_s = decode(d_out, bad);
               chk("rnd_sum", 16'(got_s), 16'(exp_s));
               chk("rnd_no_code11", {15'd0, bad}, 16'd0);
               if ((r_din <= 5'd1) || (r_din == 5'd31))
                  chk("rnd_ovld_fullscale", {15'd0, ovld}, 16'd1);
            end else begin
               chk("rnd_idle_d_out", {8'h00, d_out}, 16'h0000);
               chk("rnd_idle_ovld", {15'd0, ovld}, 16'd0);
            end
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
